cpu_reqgen: RTL and testbench
=============================

# cpu_reqgen

CPU-bus access initiator: the master end of the chip-enable / ready handshake whose slave end stretches a ready into a level that holds until chip enable is released. Accepts one read or write request at a time from an internal requester. Drives active-low chip enable, write strobe, address and write data, and waits for the slave's latched ready or a timeout. Sits between the management/sequencer logic and the register-bank CPU interface.

## Interface
- AW, 16, address width
- DW, 32, data width
- TMO, 255, max cycles in ACCESS before timeout (1..65535)
- GAP, 2, min cycles pce_ held high between accesses (>=1)

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted when req_vld & req_rdy
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  AW  access address
- req_wdat  in  DW  write data
- rsp_vld  out  1  one-cycle response pulse, no backpressure
- rsp_tmo  out  1  qualifies rsp_vld: access timed out
- rsp_rdat  out  DW  read data, valid with rsp_vld
- pce_  out  1  chip enable, active low
- pwr_  out  1  write strobe, active low, only while pce_ low
- paddr  out  AW  bus address
- pwdat  out  DW  bus write data
- prdat  in  DW  bus read data
- rdyin  in  1  slave ready, same clock domain, level held until pce_ high

## Operation
- FSM states: IDLE, ACCESS, GAP.
- IDLE: req_rdy=1. On accept, register req_wr/addr/wdat into paddr/pwdat/pwr_, clear counter, go ACCESS.
- ACCESS: pce_=0, pwr_=~wr, req_rdy=0, counter increments each cycle.
  - rdyin=1: capture prdat (reads; 0 for writes) into rsp_rdat, rsp_vld=1 / rsp_tmo=0 next cycle, go GAP.
  - counter reaches TMO-1 with rdyin=0: rsp_vld=1, rsp_tmo=1, rsp_rdat=0, go GAP.
  - rdyin=1 on the timeout cycle: ready wins, rsp_tmo=0.
- GAP: pce_=1, pwr_=1, req_rdy=0. Counter counts GAP cycles. Exits to IDLE only when the count is done and rdyin=0. A stuck-high rdyin holds GAP indefinitely, which guarantees no stale ready on the next access.
- paddr/pwdat hold their value from accept until the next accept.
- Counter width: clog2(max(TMO,GAP)+1). Saturating, never wraps.
- Reset values: pce_=1, pwr_=1, req_rdy=0 during reset and 1 the cycle after, rsp_vld=0, rsp_tmo=0, rsp_rdat=0, paddr=0, pwdat=0, state IDLE.
- Reset mid-ACCESS: pce_/pwr_ high the next cycle, no response is issued, returns to IDLE.

## Timing
- T0 accept, T1 first pce_ low cycle, rdyin sampled from T1.
- Earliest rdyin at T1 gives rsp_vld at T2 and pce_ high at T2.
- Minimum accept-to-accept with GAP=2 and an immediate ready: T0 to T4 (GAP at T2,T3, IDLE at T4 with req_rdy=1 combinational on state).
- Timeout: pce_ low exactly TMO cycles (T1..TMO), rsp_vld at T(TMO+1).
- rsp_vld is exactly one cycle and never asserts in IDLE.
- All bus outputs are registered, with no combinational path from rdyin or prdat.

## Structure
- Shared package cpu_pkg holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, GAP=2'd2)
  - default TMO and GAP constants
  - timeout read-data constant (all zeros)
- One sub-module, cpu_tmocnt: a loadable, saturating up-counter with a compare-to-limit output. It is shared by ACCESS (limit TMO) and GAP (limit GAP).

## Test plan
- Read, slave ready after 3 cycles with prdat=32'hA5A5_0001 → pce_ low 3 cycles, rsp_vld once, rsp_rdat=32'hA5A5_0001, rsp_tmo=0.
- Write addr 16'h0040 data 32'h1234_5678, ready at T1 → pwr_ low with pce_ for 1 cycle, paddr/pwdat stable, rsp_vld at T2, rsp_rdat=0.
- No ready with TMO=8 → pce_ low exactly 8 cycles, rsp_vld with rsp_tmo=1 and rsp_rdat=0, then pce_ high ≥2 cycles.
- Ready on the same cycle the counter hits TMO-1 → rsp_tmo=0, data captured.
- rdyin held high through GAP for 5 cycles → req_rdy stays 0 until the cycle after rdyin falls.
- rst asserted at the 2nd ACCESS cycle → pce_=1 the next cycle, no rsp_vld, and a following request completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings and defaults for the CPU-bus request generator.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  localparam int AW_DEF  = 16;
  localparam int DW_DEF  = 32;
  localparam int TMO_DEF = 255;
  localparam int GAP_DEF = 2;

  localparam logic [DW_DEF-1:0] TMO_RDAT = '0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cpu_reqgen_if.sv
// Request/response and chip-enable bus signals of the request generator.
interface cpu_reqgen_if
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdat;
  logic          rsp_vld;
  logic          rsp_tmo;
  logic [DW-1:0] rsp_rdat;
  logic          pce_;
  logic          pwr_;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdat;
  logic [DW-1:0] prdat;
  logic          rdyin;

  modport master (
    input  req_vld, req_wr, req_addr, req_wdat, prdat, rdyin,
    output req_rdy, rsp_vld, rsp_tmo, rsp_rdat, pce_, pwr_, paddr, pwdat
  );

  modport slave (
    output req_vld, req_wr, req_addr, req_wdat, prdat, rdyin,
    input  req_rdy, rsp_vld, rsp_tmo, rsp_rdat, pce_, pwr_, paddr, pwdat
  );
endinterface

// File: rtl/cpu_tmocnt.sv
// Loadable saturating up-counter; done is high once the count reaches lim.
module cpu_tmocnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] lim,
  output logic          done
);
  logic [CW-1:0] cnt;

  assign done = (cnt >= lim);

  // Stops at the limit, so a long stall in GAP can never wrap the count.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && !done)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cpu_reqgen.sv
// Master end of the chip-enable / latched-ready CPU bus handshake.
module cpu_reqgen
  import cpu_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int TMO = TMO_DEF,
  parameter int GAP = GAP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  cpu_reqgen_if.master bus
);
  localparam int CW = $clog2(max_int(TMO, GAP) + 1);

  state_t        state, nxt;
  logic          cnt_clr, cnt_en, cnt_done;
  logic          accept, acc_end;
  logic [CW-1:0] cnt_lim;
  logic [DW-1:0] cap_dat;

  assign bus.req_rdy = (state == S_IDLE) && !rst;
  assign cnt_lim     = (state == S_GAP) ? CW'(GAP - 1) : CW'(TMO - 1);

  cpu_tmocnt #(.CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .lim  (cnt_lim),
    .done (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    accept  = 1'b0;
    acc_end = 1'b0;
    case (state)
      S_IDLE: if (bus.req_vld) begin
        accept  = 1'b1;
        cnt_clr = 1'b1;
        nxt     = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_en = 1'b1;
        // Ready on the final timeout cycle still completes normally.
        if (bus.rdyin || cnt_done) begin
          acc_end = 1'b1;
          cnt_clr = 1'b1;
          nxt     = S_GAP;
        end
      end
      S_GAP: begin
        cnt_en = 1'b1;
        // Hold off until the slave drops its latched ready.
        if (cnt_done && !bus.rdyin) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // pwr_ low marks the current access as a write.
  assign cap_dat = (bus.rdyin && bus.pwr_) ? bus.prdat : DW'(TMO_RDAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pce_     <= 1'b1;
      bus.pwr_     <= 1'b1;
      bus.rsp_vld  <= 1'b0;
      bus.rsp_tmo  <= 1'b0;
      bus.rsp_rdat <= '0;
      bus.paddr    <= '0;
      bus.pwdat    <= '0;
    end else begin
      bus.rsp_vld <= acc_end;
      bus.rsp_tmo <= acc_end && !bus.rdyin;
      if (accept) begin
        bus.pce_  <= 1'b0;
        bus.pwr_  <= ~bus.req_wr;
        bus.paddr <= bus.req_addr;
        bus.pwdat <= bus.req_wdat;
      end
      if (acc_end) begin
        bus.pce_     <= 1'b1;
        bus.pwr_     <= 1'b1;
        bus.rsp_rdat <= cap_dat;
      end
    end
  end
endmodule

// File: tb/tb_cpu_reqgen.sv
// Directed bench for cpu_reqgen with a cycle-stamp reference model.
module tb_cpu_reqgen;
  import cpu_pkg::*;

  localparam int TMO = 8;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_reqgen_if #(.AW(16), .DW(32)) bus();

  cpu_reqgen #(.DW(32), .TMO(TMO), .GAP(GAP)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: accesses are tracked as cycle stamps, not states.
  int          cyc = 0;
  int          m_acc = -1, m_gap = -1, m_rsp = -1, m_tacc = 0;
  bit          m_idle = 1'b0, m_wr = 1'b0, m_tmo = 1'b0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdat = '0, m_rdat = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1'b1; m_acc <= -1; m_gap <= -1; m_rsp <= -1;
      m_addr <= '0; m_wdat <= '0; m_rdat <= '0; m_tmo <= 1'b0;
    end else if (m_idle && bus.req_vld) begin
      m_idle <= 1'b0; m_acc <= cyc + 1; m_tacc <= cyc;
      m_wr <= bus.req_wr; m_addr <= bus.req_addr; m_wdat <= bus.req_wdat;
    end else if (m_acc >= 0 && (bus.rdyin || (cyc - m_acc + 1) == TMO)) begin
      m_rsp  <= cyc + 1;
      m_tmo  <= !bus.rdyin;
      m_rdat <= (bus.rdyin && !m_wr) ? bus.prdat : 32'h0;
      m_gap  <= cyc + 1;
      m_acc  <= -1;
    end else if (m_gap >= 0 && (cyc - m_gap + 1) >= GAP && !bus.rdyin) begin
      m_idle <= 1'b1; m_gap <= -1;
    end
    cyc <= cyc + 1;
  end

  int          lo_cnt = 0, lo_len = 0, wr_cnt = 0, wr_len = 0, hi_cnt = 0, hi_len = 0;
  int          n_rsp = 0, last_lat = 0;
  logic        prev_pce = 1'b1, last_tmo = 1'b0;
  logic [31:0] last_rdat = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_rdy", bus.req_rdy, m_idle && !rst);
      chk("pce_", bus.pce_, !(m_acc >= 0));
      chk("pwr_", bus.pwr_, !(m_acc >= 0 && m_wr));
      chk("rsp_vld", bus.rsp_vld, m_rsp == cyc);
      chk("rsp_tmo", bus.rsp_tmo, (m_rsp == cyc) && m_tmo);
      chk("rsp_rdat", bus.rsp_rdat, m_rdat);
      chk("paddr", bus.paddr, m_addr);
      chk("pwdat", bus.pwdat, m_wdat);
      if (!bus.pce_) begin
        lo_cnt <= lo_cnt + 1;
        if (!bus.pwr_) wr_cnt <= wr_cnt + 1;
        if (prev_pce) begin hi_len <= hi_cnt; hi_cnt <= 0; end
      end else begin
        hi_cnt <= hi_cnt + 1;
        if (!prev_pce) begin lo_len <= lo_cnt; wr_len <= wr_cnt; lo_cnt <= 0; wr_cnt <= 0; end
      end
      prev_pce <= bus.pce_;
      if (bus.rsp_vld) begin
        n_rsp     <= n_rsp + 1;
        last_rdat <= bus.rsp_rdat;
        last_tmo  <= bus.rsp_tmo;
        last_lat  <= cyc - m_tacc;
      end
    end
  end

  int last_acc = 0, prev_acc = 0, fall_cyc = 0;

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.req_rdy && n < 50) begin step(); n++; end
    chk("req_rdy_wait", bus.req_rdy, 1'b1);
  endtask

  // rdy_at: access cycle (1-based) on which the slave raises ready; 0 = never.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [31:0] wdat,
                        input int rdy_at, input logic [31:0] prd, input int hold);
    wait_rdy();
    prev_acc = last_acc;
    last_acc = cyc;
    bus.req_vld = 1'b1; bus.req_wr = wr; bus.req_addr = addr; bus.req_wdat = wdat;
    step();
    bus.req_vld = 1'b0; bus.req_wr = ~wr; bus.req_addr = ~addr; bus.req_wdat = ~wdat;
    for (int k = 1; k <= TMO + 2; k++) begin
      if (bus.pce_) break;
      if (rdy_at != 0 && k >= rdy_at) begin bus.rdyin = 1'b1; bus.prdat = prd; end
      step();
    end
    chk("access_end", bus.pce_, 1'b1);
    for (int h = 0; h < hold; h++) step();
    fall_cyc = cyc;
    bus.rdyin = 1'b0;
    bus.prdat = 32'hDEAD_BEEF;
  endtask

  initial begin
    int nb;
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdat = '0;
    bus.prdat = 32'hDEAD_BEEF; bus.rdyin = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_rdy_low", bus.req_rdy, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", bus.req_rdy, 1'b1);
    chk("post_rst_pce", bus.pce_, 1'b1);
    step();

    // Read, ready on the 3rd access cycle
    nb = n_rsp;
    do_req(1'b0, 16'h0010, 32'h0, 3, 32'hA5A5_0001, 0);
    step();
    chk("rd_lo_len", lo_len, 3);
    chk("rd_wr_len", wr_len, 0);
    chk("rd_rdat", last_rdat, 32'hA5A5_0001);
    chk("rd_tmo", last_tmo, 1'b0);
    chk("rd_nrsp", n_rsp - nb, 1);

    // Write, immediate ready
    do_req(1'b1, 16'h0040, 32'h1234_5678, 1, 32'hCAFE_0000, 0);
    step();
    chk("wr_lo_len", lo_len, 1);
    chk("wr_wr_len", wr_len, 1);
    chk("wr_lat", last_lat, 2);
    chk("wr_rdat", last_rdat, 32'h0);
    chk("wr_paddr", bus.paddr, 16'h0040);
    chk("wr_pwdat", bus.pwdat, 32'h1234_5678);

    // Back-to-back: immediate-ready accesses accept every 4 cycles
    do_req(1'b1, 16'h0041, 32'h0000_0001, 1, 32'h0, 0);
    do_req(1'b0, 16'h0042, 32'h0, 1, 32'h1111_2222, 0);
    chk("acc_to_acc", last_acc - prev_acc, 4);
    step();

    // Timeout
    do_req(1'b0, 16'h0100, 32'h0, 0, 32'h0, 0);
    step();
    chk("tmo_lo_len", lo_len, TMO);
    chk("tmo_flag", last_tmo, 1'b1);
    chk("tmo_rdat", last_rdat, 32'h0);
    chk("tmo_lat", last_lat, TMO + 1);

    // Ready on the final timeout cycle wins
    do_req(1'b0, 16'h0101, 32'h0, TMO, 32'h0BAD_F00D, 0);
    step();
    chk("gap_hi_min", hi_len >= 2, 1'b1);
    chk("last_lo_len", lo_len, TMO);
    chk("last_tmo", last_tmo, 1'b0);
    chk("last_rdat", last_rdat, 32'h0BAD_F00D);

    // Ready stuck high through GAP for 5 cycles
    do_req(1'b0, 16'h0200, 32'h0, 2, 32'h7777_0000, 5);
    chk("stuck_rdy_at_fall", bus.req_rdy, 1'b0);
    step();
    chk("stuck_rdy_after", bus.req_rdy, 1'b1);
    chk("stuck_fall_gap", cyc - fall_cyc, 1);

    // Reset on the 2nd access cycle
    wait_rdy();
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 16'h0077;
    step();
    bus.req_vld = 1'b0;
    step();
    nb = n_rsp;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_pce", bus.pce_, 1'b1);
    step(); step(); step();
    chk("rst_mid_nrsp", n_rsp - nb, 0);

    // Normal access after the reset
    nb = n_rsp;
    do_req(1'b0, 16'h0300, 32'h0, 2, 32'h5555_AAAA, 0);
    step();
    chk("post_rst_rdat", last_rdat, 32'h5555_AAAA);
    chk("post_rst_nrsp", n_rsp - nb, 1);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier");
    $fatal(1);
  end
endmodule
